// File: rtl/ucore_in_mailbox.sv
// rtl/ucore_in_mailbox.sv - valid/ready input mailbox FIFO feeding a ucore FSM core
// Optional feature macro: UCORE_MAILBOX_LEVEL_EN (adds core_level occupancy output)
module ucore_in_mailbox #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_data,
  output logic [WIDTH-1:0]         core_data,
  output logic                     core_avail,
  input  logic                     core_pop_tgl
`ifdef UCORE_MAILBOX_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]   core_level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Storage is deliberately not reset; only the pointers and count define validity.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          pop_seen_q;
  logic          s_ready_q, s_ready_d;

  logic pop_req;
  logic push_fire;
  logic pop_fire;
  logic not_empty;

  // Each change of the core's toggle register is one pop request; an empty
  // FIFO swallows it because pop_seen follows the toggle unconditionally.
  always_comb begin
    not_empty = (count_q != '0);
    pop_req   = (core_pop_tgl != pop_seen_q);
    push_fire = s_valid & s_ready_q;
    pop_fire  = pop_req & not_empty;
  end

  // Next-state pointers, occupancy and registered ready.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_fire) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_fire) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    s_ready_d = (count_d != FULL_COUNT);
  end

  // Control state; reset drops ready so no handshake completes on release.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pop_seen_q <= 1'b0;
      s_ready_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pop_seen_q <= core_pop_tgl;
      s_ready_q  <= s_ready_d;
    end
  end

  // Data array write on an accepted producer word.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr_q] <= s_data;
    end
  end

  // Head presentation; avail is masked while the core's own pop is pending.
  always_comb begin
    s_ready    = s_ready_q;
    core_data  = mem[rd_ptr_q];
    core_avail = not_empty & ~pop_req;
  end

`ifdef UCORE_MAILBOX_LEVEL_EN
  // Occupancy exposed so the core can branch on fill level.
  always_comb begin
    core_level = count_q;
  end
`endif

endmodule

// File: doc/ucore_in_mailbox.md
# ucore_in_mailbox

Input mailbox that sits directly upstream of a generated `ucore_*` FSM core. It accepts words from a valid/ready producer, buffers them in a small FIFO, and presents the head word to the core as ordinary input ports. The core consumes words by toggling one of its registered output ports, which suits the core's hold-last-value output semantics.

## Interface
Parameters:
- `WIDTH`, 32: data word width in bits.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  input  1  Global clock; all state updates on the rising edge.
- `aresetn`  input  1  Reset, asynchronous, active-low.
- `s_valid`  input  1  Producer word valid.
- `s_ready`  output  1  Mailbox can accept a word; registered.
- `s_data`  input  WIDTH  Producer word.
- `core_data`  output  WIDTH  Head-of-FIFO word, driven to a core input port.
- `core_avail`  output  1  Head word is valid and not already being popped; drives a core input port.
- `core_pop_tgl`  input  1  Pop request from a core output register; each change of value requests exactly one pop.

## Operation
- Storage is a `DEPTH`-entry circular buffer with:
  - write pointer `wr_ptr` and read pointer `rd_ptr`, each `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`;
  - occupancy `count`, `$clog2(DEPTH)+1` bits, range 0..`DEPTH`.
- Push: on an edge with `s_valid & s_ready`:
  - `mem[wr_ptr] <= s_data`;
  - `wr_ptr` increments;
  - `count` increments.
- Pop request: `pop_req = (core_pop_tgl != pop_seen)`. `pop_seen` is a 1-bit register.
- On every edge, `pop_seen <= core_pop_tgl`, so each toggle is consumed exactly once.
- Pop: on an edge with `pop_req & (count != 0)`, `rd_ptr` increments and `count` decrements.
- A `pop_req` with `count == 0` is discarded silently. `pop_seen` still updates, and a later push does not inherit the stale request.
- Push and pop on the same edge leave `count` unchanged; both pointers advance.
- Pop and push never evaluate the same `count` state against each other. Push is gated only by the registered `s_ready`.
- `s_ready` is registered as next-state `(count_next != DEPTH)`.
- `core_data = mem[rd_ptr]`. It is undefined when `count == 0`.
- `core_avail = (count != 0) & ~pop_req`. Masking with `pop_req` keeps the core from seeing a stale "available" on the cycle its own pop is pending.

## Timing
- Reset values while `aresetn` is low:
  - `s_ready` = 0, `core_avail` = 0;
  - `count`, `wr_ptr`, `rd_ptr`, `pop_seen` = 0;
  - `mem` is not reset.
- `s_ready` rises on the first rising edge after `aresetn` deasserts.
- Core must hold `core_pop_tgl` at 0 out of reset. Its output registers reset to 0, so this holds automatically.
- Push latency: a word accepted at edge N is visible on `core_data` with `core_avail` = 1 from edge N (same post-edge cycle) when the FIFO was empty.
- Pop latency:
  - The core toggles at edge N.
  - `core_avail` drops combinationally in the cycle after edge N.
  - The pop commits at edge N+1.
  - The next head word, if any, is presented with `core_avail` = 1 after edge N+1.
- Full: `s_ready` = 0 the cycle after `count` reaches `DEPTH`. A pop at edge M re-asserts `s_ready` after edge M.
- Producer must hold `s_data` stable while `s_valid & ~s_ready`.
- Reset mid-operation discards all buffered words and any pending toggle immediately. No handshake completes on the edge coincident with reset release.

## Configuration
- `UCORE_MAILBOX_LEVEL_EN`
  - Defined: adds output port `core_level` (`$clog2(DEPTH)+1` bits) equal to `count`, reset 0. It lets the core branch on occupancy.
  - Undefined: the port is absent and behaviour is otherwise identical.

## Test plan
- Reset/idle: hold `aresetn` low 3 cycles, then release → `s_ready` 0 during reset and 1 one edge after release; `core_avail` stays 0.
- Single word: push `0xDEADBEEF` → `core_data` = `0xDEADBEEF` and `core_avail` = 1 after the accept edge; toggle `core_pop_tgl` 0→1 → `core_avail` 0 that cycle and stays 0 after the pop edge.
- Fill/wrap (DEPTH = 4): push 1,2,3,4 → `s_ready` 0 after the 4th accept. Pop twice, push 5,6, then pop all → order is 1,2,3,4,5,6 and pointers wrap.
- Simultaneous push/pop with `count` = 2: push 7 on the same edge as a pop → `count` stays 2 and the head advances.
- Underflow: toggle `core_pop_tgl` while empty, then push `0x11` → `core_avail` = 1 with `0x11`; the stale toggle does not drop the word.
- Reset mid-stream with 3 words buffered → after release `core_avail` = 0 and the next pushed word is the head. With `UCORE_MAILBOX_LEVEL_EN`, `core_level` tracks 3→0.
